// File: rtl/ghost_mode_scheduler_pkg.sv
// Shared types and default timings for the ghost mode scheduler and its helpers.
package ghost_mode_scheduler_pkg;

    typedef enum logic [1:0] {
        SCATTER = 2'd0,
        CHASE   = 2'd1,
        FRIGHT  = 2'd2
    } ghost_mode_t;

    localparam int DEF_SCATTER_FRAMES = 420;
    localparam int DEF_CHASE_FRAMES   = 1200;
    localparam int DEF_FRIGHT_FRAMES  = 360;
    localparam int DEF_FLASH_FRAMES   = 120;
    localparam int DEF_NUM_PAIRS      = 4;
    localparam int DEF_SCATTER_X      = 232;
    localparam int DEF_SCATTER_Y      = 32;

    localparam int         CNT_W     = 11;
    localparam logic [8:0] LFSR_SEED = 9'h1FF;
    localparam logic [8:0] TILE_MASK = 9'h1F8;

    // Snap a pixel coordinate down to the top-left pixel of its 8x8 tile.
    function automatic logic [8:0] tile_align(input logic [8:0] px);
        return px & TILE_MASK;
    endfunction

endpackage

// File: rtl/ghost_mode_scheduler_lfsr9.sv
// 9-bit Fibonacci LFSR (x^9 + x^5 + 1) used to pick random frightened targets.
module ghost_lfsr9
    import ghost_mode_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output logic [8:0] out
);

    logic [8:0] state_q;

    // The all-ones seed keeps the register off the all-zero lock-up state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LFSR_SEED;
        end else if (step) begin
            state_q <= {state_q[7:0], state_q[8] ^ state_q[4]};
        end
    end

    assign out = state_q;

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Ghost behaviour sequencer: scatter/chase timetable, frightened override, and target tile selection.
module ghost_mode_scheduler
    import ghost_mode_scheduler_pkg::*;
#(
    parameter int         SCATTER_FRAMES = DEF_SCATTER_FRAMES,
    parameter int         CHASE_FRAMES   = DEF_CHASE_FRAMES,
    parameter int         FRIGHT_FRAMES  = DEF_FRIGHT_FRAMES,
    parameter int         FLASH_FRAMES   = DEF_FLASH_FRAMES,
    parameter int         NUM_PAIRS      = DEF_NUM_PAIRS,
    parameter logic [8:0] SCATTER_X      = 9'(DEF_SCATTER_X),
    parameter logic [8:0] SCATTER_Y      = 9'(DEF_SCATTER_Y)
) (
    input  logic        vga_pix_clk,
    input  logic        rst,
    input  logic        frame_stb,
    input  logic        game_run,
    input  logic        power_pellet,
    input  logic [8:0]  x_pac,
    input  logic [8:0]  y_pac,
    output ghost_mode_t mode,
    output logic        fright_flash,
    output logic        reverse_req,
    output logic [2:0]  phase_idx,
    output logic [8:0]  target_x,
    output logic [8:0]  target_y
);

    localparam logic [CNT_W-1:0] SCATTER_LOAD = 11'(SCATTER_FRAMES - 1);
    localparam logic [CNT_W-1:0] CHASE_LOAD   = 11'(CHASE_FRAMES - 1);
    localparam logic [CNT_W-1:0] FRIGHT_LOAD  = 11'(FRIGHT_FRAMES - 1);
    localparam logic [CNT_W-1:0] FLASH_LIM    = 11'(FLASH_FRAMES);
    localparam logic [2:0]       PAIRS_LIM    = 3'(NUM_PAIRS);

    logic tick;
    logic pellet;
    logic chase_locked;

    ghost_mode_t      mode_q, mode_n;
    ghost_mode_t      saved_q, saved_n;
    logic [CNT_W-1:0] phase_cnt_q, phase_cnt_n;
    logic [CNT_W-1:0] fright_cnt_q, fright_cnt_n;
    logic [2:0]       phase_idx_q, phase_idx_n;
    logic             rev_q, rev_n;

    logic [8:0] lfsr_val;
    logic [8:0] fr_tx, fr_ty;
    logic [8:0] tx_q, ty_q;

    assign tick         = frame_stb & game_run;
    assign pellet       = power_pellet & game_run;
    assign chase_locked = (phase_idx_q == PAIRS_LIM);

    ghost_lfsr9 u_lfsr (
        .clk  (vga_pix_clk),
        .rst  (rst),
        .step (frame_stb),
        .out  (lfsr_val)
    );

    always_ff @(posedge vga_pix_clk or posedge rst) begin
        if (rst) begin
            mode_q       <= SCATTER;
            saved_q      <= SCATTER;
            phase_cnt_q  <= SCATTER_LOAD;
            fright_cnt_q <= '0;
            phase_idx_q  <= '0;
            rev_q        <= 1'b0;
        end else begin
            mode_q       <= mode_n;
            saved_q      <= saved_n;
            phase_cnt_q  <= phase_cnt_n;
            fright_cnt_q <= fright_cnt_n;
            phase_idx_q  <= phase_idx_n;
            rev_q        <= rev_n;
        end
    end

    // A pellet pre-empts any phase expiry in the same cycle; phase_cnt is left at
    // zero so the deferred phase change fires on the first tick after fright ends.
    always_comb begin
        mode_n       = mode_q;
        saved_n      = saved_q;
        phase_cnt_n  = phase_cnt_q;
        fright_cnt_n = fright_cnt_q;
        phase_idx_n  = phase_idx_q;
        rev_n        = 1'b0;
        case (mode_q)
            FRIGHT: begin
                if (pellet) begin
                    fright_cnt_n = FRIGHT_LOAD;
                end else if (tick) begin
                    if (fright_cnt_q == '0) begin
                        mode_n = saved_q;
                    end else begin
                        fright_cnt_n = fright_cnt_q - 11'd1;
                    end
                end
            end
            default: begin
                if (pellet) begin
                    mode_n       = FRIGHT;
                    saved_n      = mode_q;
                    fright_cnt_n = FRIGHT_LOAD;
                    rev_n        = 1'b1;
                end else if (tick) begin
                    if (phase_cnt_q != '0) begin
                        if (!chase_locked) begin
                            phase_cnt_n = phase_cnt_q - 11'd1;
                        end
                    end else if (mode_q == SCATTER) begin
                        mode_n      = CHASE;
                        phase_cnt_n = CHASE_LOAD;
                        rev_n       = 1'b1;
                    end else if (!chase_locked) begin
                        phase_idx_n = phase_idx_q + 3'd1;
                        phase_cnt_n = SCATTER_LOAD;
                        if (phase_idx_n != PAIRS_LIM) begin
                            mode_n = SCATTER;
                            rev_n  = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    // Frightened target: column 0..31, row 4..35 of the maze, both from the LFSR.
    assign fr_tx = {1'b0, lfsr_val[4:0], 3'b000};
    assign fr_ty = ({4'b0000, lfsr_val[8:4]} + 9'd4) << 3;

    always_ff @(posedge vga_pix_clk or posedge rst) begin
        if (rst) begin
            tx_q <= SCATTER_X;
            ty_q <= SCATTER_Y;
        end else if (tick) begin
            case (mode_n)
                CHASE: begin
                    tx_q <= tile_align(x_pac);
                    ty_q <= tile_align(y_pac);
                end
                FRIGHT: begin
                    tx_q <= fr_tx;
                    ty_q <= fr_ty;
                end
                default: begin
                    tx_q <= SCATTER_X;
                    ty_q <= SCATTER_Y;
                end
            endcase
        end
    end

    always_comb begin
        mode         = mode_q;
        reverse_req  = rev_q;
        phase_idx    = phase_idx_q;
        fright_flash = (mode_q == FRIGHT) && (fright_cnt_q < FLASH_LIM);
        target_x     = tx_q;
        target_y     = ty_q;
    end

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Bench for ghost_mode_scheduler: vector table, directed corner sequences, and randomized traffic vs. a model.
module tb_ghost_mode_scheduler;

    localparam int SC_F = 4;
    localparam int CH_F = 6;
    localparam int FR_F = 5;
    localparam int FL_F = 2;
    localparam int NP   = 2;
    localparam int SX   = 232;
    localparam int SY   = 32;

    localparam int M_SC = 0;
    localparam int M_CH = 1;
    localparam int M_FR = 2;

    logic       vga_pix_clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_stb = 1'b0;
    logic       game_run = 1'b0;
    logic       power_pellet = 1'b0;
    logic [8:0] x_pac = '0;
    logic [8:0] y_pac = '0;
    logic [1:0] mode;
    logic       fright_flash;
    logic       reverse_req;
    logic [2:0] phase_idx;
    logic [8:0] target_x;
    logic [8:0] target_y;

    ghost_mode_scheduler #(
        .SCATTER_FRAMES (SC_F),
        .CHASE_FRAMES   (CH_F),
        .FRIGHT_FRAMES  (FR_F),
        .FLASH_FRAMES   (FL_F),
        .NUM_PAIRS      (NP),
        .SCATTER_X      (9'(SX)),
        .SCATTER_Y      (9'(SY))
    ) dut (
        .vga_pix_clk  (vga_pix_clk),
        .rst          (rst),
        .frame_stb    (frame_stb),
        .game_run     (game_run),
        .power_pellet (power_pellet),
        .x_pac        (x_pac),
        .y_pac        (y_pac),
        .mode         (mode),
        .fright_flash (fright_flash),
        .reverse_req  (reverse_req),
        .phase_idx    (phase_idx),
        .target_x     (target_x),
        .target_y     (target_y)
    );

    always #5 vga_pix_clk = ~vga_pix_clk;

    int n_vec = 0;
    int n_err = 0;
    int rev_seen = 0;

    // Reference model state, kept as plain integers.
    int m_mode, m_saved, m_idx, m_pcnt, m_fcnt, m_rev, m_flash, m_tx, m_ty, m_lfsr;

    function automatic int lfsr_adv(input int v);
        return ((v << 1) & 9'h1FE) | (((v >> 8) ^ (v >> 4)) & 1);
    endfunction

    task automatic model_reset();
        m_mode = M_SC; m_saved = M_SC; m_idx = 0; m_pcnt = SC_F - 1; m_fcnt = 0;
        m_rev = 0; m_flash = 0; m_tx = SX; m_ty = SY; m_lfsr = 9'h1FF;
    endtask

    task automatic model_step(input bit s, input bit r, input bit p, input int x, input int y);
        bit tick, pev;
        int nm;
        tick = s && r;
        pev = p && r;
        nm = m_mode;
        m_rev = 0;
        if (m_mode == M_FR) begin
            if (pev) m_fcnt = FR_F - 1;
            else if (tick) begin
                if (m_fcnt == 0) nm = m_saved;
                else m_fcnt = m_fcnt - 1;
            end
        end else if (pev) begin
            nm = M_FR; m_saved = m_mode; m_fcnt = FR_F - 1; m_rev = 1;
        end else if (tick) begin
            if (m_pcnt > 0) begin
                if (m_idx < NP) m_pcnt = m_pcnt - 1;
            end else if (m_mode == M_SC) begin
                nm = M_CH; m_pcnt = CH_F - 1; m_rev = 1;
            end else if (m_idx < NP) begin
                m_idx = m_idx + 1;
                m_pcnt = SC_F - 1;
                if (m_idx < NP) begin nm = M_SC; m_rev = 1; end
            end
        end
        if (tick) begin
            if (nm == M_SC) begin m_tx = SX; m_ty = SY; end
            else if (nm == M_CH) begin m_tx = (x / 8) * 8; m_ty = (y / 8) * 8; end
            else begin m_tx = (m_lfsr % 32) * 8; m_ty = ((m_lfsr / 16) + 4) * 8; end
        end
        if (s) m_lfsr = lfsr_adv(m_lfsr);
        m_mode = nm;
        m_flash = (m_mode == M_FR && m_fcnt < FL_F) ? 1 : 0;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".mode"}, 16'(mode), 16'(m_mode));
        chk({tag, ".reverse_req"}, 16'(reverse_req), 16'(m_rev));
        chk({tag, ".fright_flash"}, 16'(fright_flash), 16'(m_flash));
        chk({tag, ".phase_idx"}, 16'(phase_idx), 16'(m_idx));
        chk({tag, ".target_x"}, 16'(target_x), 16'(m_tx));
        chk({tag, ".target_y"}, 16'(target_y), 16'(m_ty));
    endtask

    task automatic step(input string tag, input bit s, input bit r, input bit p,
                        input logic [8:0] x, input logic [8:0] y);
        @(negedge vga_pix_clk);
        frame_stb = s; game_run = r; power_pellet = p; x_pac = x; y_pac = y;
        @(posedge vga_pix_clk);
        model_step(s, r, p, int'(x), int'(y));
        #1;
        if (reverse_req === 1'b1) rev_seen++;
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge vga_pix_clk);
        frame_stb = 0; game_run = 0; power_pellet = 0;
        rst = 1'b1;
        @(posedge vga_pix_clk);
        @(negedge vga_pix_clk);
        rst = 1'b0;
        model_reset();
        rev_seen = 0;
    endtask

    typedef struct {
        bit         s, r, p;
        logic [8:0] x, y;
        logic [1:0] e_mode;
        logic       e_rev;
        logic [2:0] e_idx;
        logic [8:0] e_tx, e_ty;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int sm, stx, sty, sidx, lf0;
        int fl_exp[6];

        tbl[0] = '{1, 1, 0, 9'd37, 9'd50, 2'd0, 1'b0, 3'd0, 9'd232, 9'd32};
        tbl[1] = '{1, 1, 0, 9'd37, 9'd50, 2'd0, 1'b0, 3'd0, 9'd232, 9'd32};
        tbl[2] = '{1, 1, 0, 9'd37, 9'd50, 2'd0, 1'b0, 3'd0, 9'd232, 9'd32};
        tbl[3] = '{1, 1, 0, 9'd37, 9'd50, 2'd1, 1'b1, 3'd0, 9'd32,  9'd48};
        tbl[4] = '{1, 1, 0, 9'd37, 9'd50, 2'd1, 1'b0, 3'd0, 9'd32,  9'd48};
        tbl[5] = '{0, 1, 0, 9'd99, 9'd99, 2'd1, 1'b0, 3'd0, 9'd32,  9'd48};
        tbl[6] = '{1, 0, 1, 9'd99, 9'd99, 2'd1, 1'b0, 3'd0, 9'd32,  9'd48};

        // Reset state
        model_reset();
        repeat (2) @(posedge vga_pix_clk);
        #1;
        check_model("reset");
        chk("reset.target_x_lit", 16'(target_x), 16'd232);
        do_reset();

        // 1: table vectors from reset through the first scatter->chase change
        for (int i = 0; i < 7; i++) begin
            step("t1", tbl[i].s, tbl[i].r, tbl[i].p, tbl[i].x, tbl[i].y);
            chk($sformatf("t1[%0d].mode", i), 16'(mode), 16'(tbl[i].e_mode));
            chk($sformatf("t1[%0d].rev", i), 16'(reverse_req), 16'(tbl[i].e_rev));
            chk($sformatf("t1[%0d].idx", i), 16'(phase_idx), 16'(tbl[i].e_idx));
            chk($sformatf("t1[%0d].tx", i), 16'(target_x), 16'(tbl[i].e_tx));
            chk($sformatf("t1[%0d].ty", i), 16'(target_y), 16'(tbl[i].e_ty));
        end
        chk("t1.rev_pulses", 16'(rev_seen), 16'd1);

        // 2: run both pairs, then permanent chase
        guard = 0;
        while (phase_idx !== 3'(NP) && guard < 200) begin
            step("t2", 1, 1, 0, 9'(8 * guard), 9'd100);
            guard++;
        end
        chk("t2.idx_reached", 16'(phase_idx), 16'(NP));
        rev_seen = 0;
        for (int i = 0; i < 50; i++) step("t2b", 1, 1, 0, 9'd64, 9'd72);
        chk("t2.mode_locked", 16'(mode), 16'(M_CH));
        chk("t2.no_reverse", 16'(rev_seen), 16'd0);

        // 3: pellet (on a tick) in chase, flash window and return to chase
        fl_exp = '{0, 0, 0, 1, 1, 0};
        for (int k = 0; k < 6; k++) begin
            step("t3", 1, 1, (k == 0), 9'd200, 9'd16);
            if (k == 0) begin
                chk("t3.fright", 16'(mode), 16'(M_FR));
                chk("t3.rev_enter", 16'(reverse_req), 16'd1);
            end
            chk($sformatf("t3.flash[%0d]", k + 1), 16'(fright_flash), 16'(fl_exp[k]));
        end
        chk("t3.exit_mode", 16'(mode), 16'(M_CH));
        chk("t3.exit_rev", 16'(reverse_req), 16'd0);

        // 4: pellet on the scatter expiry tick defers the phase change
        do_reset();
        for (int k = 0; k < SC_F - 1; k++) step("t4a", 1, 1, 0, 9'd40, 9'd40);
        step("t4b", 1, 1, 1, 9'd40, 9'd40);
        chk("t4.fright", 16'(mode), 16'(M_FR));
        chk("t4.rev_enter", 16'(reverse_req), 16'd1);
        for (int k = 0; k < FR_F; k++) step("t4c", 1, 1, 0, 9'd40, 9'd40);
        chk("t4.back_scatter", 16'(mode), 16'(M_SC));
        chk("t4.exit_rev", 16'(reverse_req), 16'd0);
        step("t4d", 1, 1, 0, 9'd40, 9'd40);
        chk("t4.deferred_chase", 16'(mode), 16'(M_CH));
        chk("t4.deferred_rev", 16'(reverse_req), 16'd1);

        // 5: game_run low freezes everything except the LFSR
        sm = int'(mode); stx = int'(target_x); sty = int'(target_y); sidx = int'(phase_idx);
        lf0 = m_lfsr;
        rev_seen = 0;
        for (int k = 0; k < 20; k++) step("t5", 1, 0, (k == 9), 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
        chk("t5.mode", 16'(mode), 16'(sm));
        chk("t5.tx", 16'(target_x), 16'(stx));
        chk("t5.ty", 16'(target_y), 16'(sty));
        chk("t5.idx", 16'(phase_idx), 16'(sidx));
        chk("t5.no_reverse", 16'(rev_seen), 16'd0);
        for (int k = 0; k < 20; k++) lf0 = lfsr_adv(lf0);
        chk("t5.lfsr", 16'(dut.u_lfsr.out), 16'(lf0));
        for (int k = 0; k < 8; k++) step("t5b", 1, 1, 0, 9'd123, 9'd77);

        // Randomized traffic against the model
        for (int b = 0; b < 4; b++) begin
            do_reset();
            for (int k = 0; k < 600; k++) begin
                step("rnd", 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                     ($urandom_range(0, 39) == 0), 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
            end
        end

        // 6: asynchronous reset mid-fright, observed before the next edge
        step("t6a", 0, 1, 1, 9'd10, 9'd10);
        step("t6b", 1, 1, 0, 9'd10, 9'd10);
        step("t6c", 1, 1, 0, 9'd10, 9'd10);
        chk("t6.in_fright", 16'(mode), 16'(M_FR));
        @(posedge vga_pix_clk);
        #2 rst = 1'b1;
        #1;
        chk("t6.mode", 16'(mode), 16'(M_SC));
        chk("t6.rev", 16'(reverse_req), 16'd0);
        chk("t6.flash", 16'(fright_flash), 16'd0);
        chk("t6.idx", 16'(phase_idx), 16'd0);
        chk("t6.tx", 16'(target_x), 16'd232);
        chk("t6.ty", 16'(target_y), 16'd32);
        model_reset();
        @(negedge vga_pix_clk);
        frame_stb = 0; game_run = 0; power_pellet = 0;
        @(negedge vga_pix_clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) step("t6d", 1, 1, 0, 9'd88, 9'd96);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
